fp_status_unit: RTL and testbench
=================================

# fp_status_unit

Sequential consumer of the floating-point multiplier's exception outputs. Accepts one result per valid/ready handshake, accumulates IEEE-style sticky status flags, and counts operations and traps. Results whose flags hit an enabled trap are queued in a small FIFO for software readout, with an interrupt line. Sits between the multiplier datapath (`z` plus the six status flags) and the control/status register interface.

## Interface
- `FIFO_DEPTH`, default 4: trap-record FIFO entries; power of two, at least 2.
- `CNT_W`, default 16: width of the op and trap counters.
- `STALL_ON_FULL`, default 1:
  - 1: deassert `in_ready` while the FIFO is full.
  - 0: always ready; trapping results are dropped when the FIFO is full.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: result available.
- `in_ready` out 1: block accepts this cycle.
- `in_z` in 32: multiplier result.
- `in_flags` in 6: {inexact_f, huge_f, tiny_f, nan_f, inf_f, zero_f}, bit 0 = zero_f.
- `in_round` in `round_mode`: rounding mode used for this result.
- `trap_en` in 6: per-flag trap enable, same bit order as `in_flags`.
- `clr_sticky` in 1: one-cycle pulse; clears `sticky` and `drop_sticky`.
- `clr_cnt` in 1: one-cycle pulse; zeroes both counters.
- `sticky` out 6: OR of all accepted flags since the last reset or clear.
- `drop_sticky` out 1: set when a trap record was lost (only possible with `STALL_ON_FULL`=0).
- `op_count` out `CNT_W`: accepted results, saturating.
- `trap_count` out `CNT_W`: trapping results, saturating; includes dropped ones.
- `trap_irq` out 1: high while the FIFO is non-empty.
- `trap_rd_valid` out 1: FIFO head valid.
- `trap_rd_ready` in 1: consumer pops the head.
- `trap_rd_z` out 32: head result.
- `trap_rd_flags` out 6: head flags.
- `trap_rd_round` out `round_mode`: head rounding mode.

## Operation
- Accept: `acc = in_valid & in_ready`.
- Trap condition: `hit = acc & |(in_flags & trap_en)`.
- On `acc`:
  - `sticky <= sticky | in_flags`.
  - `op_count` increments and saturates at all-ones.
- On `hit`:
  - `trap_count` increments, saturating.
  - If the FIFO is not full: push {in_z, in_flags, in_round}.
  - Else (drop mode only): set `drop_sticky`.
- `clr_sticky` together with `acc`: `sticky <= in_flags`; `drop_sticky <= 1` only if this cycle drops. The new event wins.
- `clr_cnt` together with `acc`/`hit`: counters load 1 (or 0 for `trap_count` on a non-hit).
- FIFO:
  - Circular buffer with read/write pointers of width log2(`FIFO_DEPTH`)+1; the MSB distinguishes full from empty.
  - Pop when `trap_rd_valid & trap_rd_ready`.
  - Push and pop in the same cycle on a non-empty, non-full FIFO: count unchanged.
  - Pop and push in the same cycle with the FIFO full: the push is still rejected, because fullness is sampled from registered state at the start of the cycle.
- `in_ready`:
  - `STALL_ON_FULL`=1: `in_ready = !full`, with no regard to whether the result would trap. This keeps the path free of `in_flags`.
  - `STALL_ON_FULL`=0: `in_ready = 1`.
- Output-stage FSM, 2 states:
  - IDLE: FIFO empty; `trap_irq`=0, `trap_rd_valid`=0.
  - PEND: FIFO non-empty; `trap_irq`=1, `trap_rd_valid`=1, head fields driven.
  - IDLE→PEND on any push.
  - PEND→IDLE when a pop leaves the count at 0 with no simultaneous push.
- No `round_mode` value is treated as illegal; it is stored verbatim.

## Timing
- Reset values:
  - `sticky`=0, `drop_sticky`=0.
  - Counters = 0.
  - FIFO empty, FSM IDLE, `trap_irq`=0, `trap_rd_valid`=0.
  - `trap_rd_*` data = 0.
  - `in_ready` = 1.
- Reset asserted mid-operation discards queued records immediately, asynchronously.
- Latency from the accept edge:
  - `sticky`, counters and `drop_sticky` update at that edge and are visible the next cycle.
  - `trap_rd_valid`/`trap_irq` rise one cycle after the pushing edge.
- No combinational path from `in_*` to any output.
- `trap_rd_*` is stable while `trap_rd_valid` is high and not popped.

## Structure
- Add `status_pkg`:
  - Flag bit-index localparams (`FLG_ZERO`=0 … `FLG_INEXACT`=5).
  - `trap_rec_t` packed struct {z, flags, round}.
  - FSM state enum.
- Imports `round_pkg` for `round_mode`.
- One sub-module, `trap_fifo`: parameterized synchronous FIFO of `trap_rec_t` with full/empty outputs.

## Test plan
- Reset, then 3 results with flags 6'h20, 6'h01, 6'h00 and `trap_en`=0 → `sticky`=6'h21, `op_count`=3, `trap_count`=0, `trap_irq`=0.
- `trap_en`=6'h04, result z=32'h7FC00000 with flags 6'h04 → one cycle later `trap_rd_valid`=1, `trap_rd_z`=32'h7FC00000, `trap_rd_flags`=6'h04; pop → `trap_irq`=0 the next cycle.
- `STALL_ON_FULL`=1: 5 back-to-back trapping results with no pops → `in_ready`=0 after 4 are accepted; one pop → `in_ready`=1 the next cycle, 5th accepted, records read back in order.
- `STALL_ON_FULL`=0: 6 trapping results → 4 stored, `drop_sticky`=1, `trap_count`=6.
- `clr_sticky` in the same cycle as an accepted result with flags 6'h02 → `sticky`=6'h02; `CNT_W`=4 with 20 accepts → `op_count`=15.
- `rst` asserted with 2 queued records → `trap_rd_valid` and `trap_irq` drop without waiting for a clock edge, and all counters are 0.

Source files
------------

// File: rtl/round_pkg.sv
// Rounding-mode encoding shared by the multiplier datapath and its consumers.
package round_pkg;

  // Kept as a plain 3-bit vector so that every encoding travels through untouched.
  typedef logic [2:0] round_mode;

  localparam round_mode RND_NEAR_EVEN = 3'd0;
  localparam round_mode RND_ZERO      = 3'd1;
  localparam round_mode RND_POS_INF   = 3'd2;
  localparam round_mode RND_NEG_INF   = 3'd3;
  localparam round_mode RND_NEAR_MAX  = 3'd4;

endpackage

// File: rtl/status_pkg.sv
// Types and flag indices for the floating-point status/trap unit.
package status_pkg;

  import round_pkg::*;

  localparam int unsigned FLG_ZERO    = 0;
  localparam int unsigned FLG_INF     = 1;
  localparam int unsigned FLG_NAN     = 2;
  localparam int unsigned FLG_TINY    = 3;
  localparam int unsigned FLG_HUGE    = 4;
  localparam int unsigned FLG_INEXACT = 5;
  localparam int unsigned NUM_FLAGS   = 6;

  typedef struct packed {
    logic [31:0] z;
    logic [5:0]  flags;
    round_mode   round;
  } trap_rec_t;

  typedef enum logic [0:0] {StIdle, StPend} out_state_e;

endpackage

// File: rtl/trap_fifo.sv
// Circular FIFO of trap records; pointers carry one extra wrap bit to tell full from empty.
module trap_fifo
  import status_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  trap_rec_t  wdata,
  input  logic       pop,
  output trap_rec_t  rdata,
  output logic       full,
  output logic       empty,
  output logic [AW:0] count
);

  trap_rec_t   mem [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  // Fullness comes from registered pointers, so a pop never frees room for a same-cycle push.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign count   = wr_q - rd_q;
  // Head reads as zero when nothing is queued (including straight out of reset).
  assign rdata   = empty ? '0 : mem[rd_q[AW-1:0]];

  // Pointer registers; reset empties the queue asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage array; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fp_status_unit.sv
// Sticky-flag accumulator, op/trap counters and trap-record queue for multiplier results.
module fp_status_unit
  import round_pkg::*;
  import status_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned CNT_W         = 16,
  parameter bit          STALL_ON_FULL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_z,
  input  logic [5:0]       in_flags,
  input  round_mode        in_round,
  input  logic [5:0]       trap_en,
  input  logic             clr_sticky,
  input  logic             clr_cnt,
  output logic [5:0]       sticky,
  output logic             drop_sticky,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] trap_count,
  output logic             trap_irq,
  output logic             trap_rd_valid,
  input  logic             trap_rd_ready,
  output logic [31:0]      trap_rd_z,
  output logic [5:0]       trap_rd_flags,
  output round_mode        trap_rd_round
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic             acc, hit, push, pop, full, empty;
  logic [AW:0]      fifo_count;
  trap_rec_t        wr_rec, rd_rec;
  logic [5:0]       sticky_q, sticky_d;
  logic             drop_q, drop_d;
  logic [CNT_W-1:0] op_q, op_d, trap_q, trap_d;
  out_state_e       state_q, state_d;

  // Stalling depends only on registered fullness, keeping in_flags off the ready path.
  assign in_ready = STALL_ON_FULL ? ~full : 1'b1;
  assign acc      = in_valid & in_ready;
  assign hit      = acc & (|(in_flags & trap_en));
  assign push     = hit & ~full;
  assign pop      = trap_rd_valid & trap_rd_ready & ~empty;
  assign wr_rec   = '{z: in_z, flags: in_flags, round: in_round};

  trap_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_rec),
    .pop   (pop),
    .rdata (rd_rec),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // Sticky flags; a clear coinciding with a new event keeps the new event.
  always_comb begin
    sticky_d = clr_sticky ? 6'b0 : sticky_q;
    drop_d   = clr_sticky ? 1'b0 : drop_q;
    if (acc)         sticky_d = sticky_d | in_flags;
    if (hit && full) drop_d   = 1'b1;
  end

  // Saturating counters; a clear coinciding with an event loads the event's count of one.
  always_comb begin
    op_d   = op_q;
    trap_d = trap_q;
    if (clr_cnt) begin
      op_d   = {{(CNT_W-1){1'b0}}, acc};
      trap_d = {{(CNT_W-1){1'b0}}, hit};
    end else begin
      if (acc && (op_q != '1))   op_d   = op_q + 1'b1;
      if (hit && (trap_q != '1)) trap_d = trap_q + 1'b1;
    end
  end

  // Output-stage next state: pending while any record is queued.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (push) state_d = StPend;
      StPend:  if (pop && !push && (fifo_count == (AW+1)'(1))) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Status, counter and FSM registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= '0;
      drop_q   <= 1'b0;
      op_q     <= '0;
      trap_q   <= '0;
      state_q  <= StIdle;
    end else begin
      sticky_q <= sticky_d;
      drop_q   <= drop_d;
      op_q     <= op_d;
      trap_q   <= trap_d;
      state_q  <= state_d;
    end
  end

  assign sticky        = sticky_q;
  assign drop_sticky   = drop_q;
  assign op_count      = op_q;
  assign trap_count    = trap_q;
  assign trap_irq      = (state_q == StPend);
  assign trap_rd_valid = (state_q == StPend);
  assign trap_rd_z     = rd_rec.z;
  assign trap_rd_flags = rd_rec.flags;
  assign trap_rd_round = rd_rec.round;

endmodule

// File: tb/tb_fp_status_unit.sv
// Bench for fp_status_unit: a stalling instance and a dropping 4-bit-counter instance share stimulus.
module tb_fp_status_unit;

  import round_pkg::*;
  import status_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_z;
  logic [5:0]  in_flags;
  round_mode   in_round;
  logic [5:0]  trap_en;
  logic        clr_sticky, clr_cnt, trap_rd_ready;

  logic        a_in_ready, a_drop, a_irq, a_rd_valid;
  logic [5:0]  a_sticky, a_rd_flags;
  logic [15:0] a_op, a_trap;
  logic [31:0] a_rd_z;
  round_mode   a_rd_round;

  logic        b_in_ready, b_drop, b_irq, b_rd_valid;
  logic [5:0]  b_sticky, b_rd_flags;
  logic [3:0]  b_op, b_trap;
  logic [31:0] b_rd_z;
  round_mode   b_rd_round;

  always #5 clk = ~clk;

  fp_status_unit #(.FIFO_DEPTH(DEPTH), .CNT_W(16), .STALL_ON_FULL(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_z(in_z),
    .in_flags(in_flags), .in_round(in_round), .trap_en(trap_en), .clr_sticky(clr_sticky),
    .clr_cnt(clr_cnt), .sticky(a_sticky), .drop_sticky(a_drop), .op_count(a_op),
    .trap_count(a_trap), .trap_irq(a_irq), .trap_rd_valid(a_rd_valid),
    .trap_rd_ready(trap_rd_ready), .trap_rd_z(a_rd_z), .trap_rd_flags(a_rd_flags),
    .trap_rd_round(a_rd_round)
  );

  fp_status_unit #(.FIFO_DEPTH(DEPTH), .CNT_W(4), .STALL_ON_FULL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_z(in_z),
    .in_flags(in_flags), .in_round(in_round), .trap_en(trap_en), .clr_sticky(clr_sticky),
    .clr_cnt(clr_cnt), .sticky(b_sticky), .drop_sticky(b_drop), .op_count(b_op),
    .trap_count(b_trap), .trap_irq(b_irq), .trap_rd_valid(b_rd_valid),
    .trap_rd_ready(trap_rd_ready), .trap_rd_z(b_rd_z), .trap_rd_flags(b_rd_flags),
    .trap_rd_round(b_rd_round)
  );

  int checks = 0;
  int errors = 0;

  // Reference state, index 0 = stalling instance, 1 = dropping instance.
  int        m_sticky[2], m_drop[2], m_op[2], m_trap[2], m_occ[2];
  int        m_max[2]   = '{65535, 15};
  bit        m_stall[2] = '{1'b1, 1'b0};
  trap_rec_t exp_a[$];
  trap_rec_t exp_b[$];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void reset_model();
    for (int d = 0; d < 2; d++) begin
      m_sticky[d] = 0; m_drop[d] = 0; m_op[d] = 0; m_trap[d] = 0; m_occ[d] = 0;
    end
    exp_a.delete();
    exp_b.delete();
  endfunction

  // Advance the reference by one clock edge using the inputs presented in that cycle.
  function automatic void model_step();
    for (int d = 0; d < 2; d++) begin
      bit full, ready, acc, hit, pop;
      int f;
      trap_rec_t rec;
      full  = (m_occ[d] >= DEPTH);
      ready = m_stall[d] ? !full : 1'b1;
      acc   = in_valid && ready;
      hit   = acc && ((in_flags & trap_en) != 6'd0);
      pop   = (m_occ[d] > 0) && trap_rd_ready;
      f     = acc ? int'(in_flags) : 0;
      m_sticky[d] = clr_sticky ? f : (m_sticky[d] | f);
      m_drop[d]   = (clr_sticky ? 0 : m_drop[d]) | int'(hit && full);
      if (clr_cnt) begin
        m_op[d]   = int'(acc);
        m_trap[d] = int'(hit);
      end else begin
        if (acc && m_op[d] < m_max[d])   m_op[d]++;
        if (hit && m_trap[d] < m_max[d]) m_trap[d]++;
      end
      if (hit && !full) begin
        rec = '{z: in_z, flags: in_flags, round: in_round};
        if (d == 0) exp_a.push_back(rec);
        else        exp_b.push_back(rec);
        m_occ[d]++;
      end
      if (pop) m_occ[d]--;
    end
  endfunction

  function automatic void check_status();
    check("a_in_ready", a_in_ready, m_occ[0] < DEPTH);
    check("a_sticky", a_sticky, m_sticky[0]);
    check("a_drop_sticky", a_drop, m_drop[0]);
    check("a_op_count", a_op, m_op[0]);
    check("a_trap_count", a_trap, m_trap[0]);
    check("a_trap_irq", a_irq, m_occ[0] > 0);
    check("a_rd_valid", a_rd_valid, m_occ[0] > 0);
    check("b_in_ready", b_in_ready, 1'b1);
    check("b_sticky", b_sticky, m_sticky[1]);
    check("b_drop_sticky", b_drop, m_drop[1]);
    check("b_op_count", b_op, m_op[1]);
    check("b_trap_count", b_trap, m_trap[1]);
    check("b_trap_irq", b_irq, m_occ[1] > 0);
    check("b_rd_valid", b_rd_valid, m_occ[1] > 0);
  endfunction

  // Scoreboard monitor: every handshake on a read port pops and compares one expected record.
  always @(negedge clk) begin
    trap_rec_t rec;
    if (!rst && a_rd_valid && trap_rd_ready) begin
      check("a_pop_expected", exp_a.size() != 0, 1'b1);
      if (exp_a.size() != 0) begin
        rec = exp_a.pop_front();
        check("a_rd_z", a_rd_z, rec.z);
        check("a_rd_flags", a_rd_flags, rec.flags);
        check("a_rd_round", a_rd_round, rec.round);
      end
    end
    if (!rst && b_rd_valid && trap_rd_ready) begin
      check("b_pop_expected", exp_b.size() != 0, 1'b1);
      if (exp_b.size() != 0) begin
        rec = exp_b.pop_front();
        check("b_rd_z", b_rd_z, rec.z);
        check("b_rd_flags", b_rd_flags, rec.flags);
        check("b_rd_round", b_rd_round, rec.round);
      end
    end
  end

  task automatic cyc(input bit v, input logic [31:0] z, input logic [5:0] f, input logic [2:0] r,
                     input logic [5:0] en, input bit cs, input bit cc, input bit rdy);
    in_valid = v; in_z = z; in_flags = f; in_round = r; trap_en = en;
    clr_sticky = cs; clr_cnt = cc; trap_rd_ready = rdy;
    @(posedge clk);
    model_step();
    #1;
    check_status();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 6'd0, 3'd0, 6'd0, 1'b0, 1'b0, rdy);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_z = '0; in_flags = '0; in_round = '0; trap_en = '0;
    clr_sticky = 1'b0; clr_cnt = 1'b0; trap_rd_ready = 1'b0;
    reset_model();
    #12;
    check("rst_rd_z", a_rd_z, 32'd0);
    check("rst_rd_flags", b_rd_flags, 6'd0);
    check_status();
    @(negedge clk);
    rst = 1'b0;

    // Sticky accumulation without traps.
    cyc(1'b1, 32'h3F800000, 6'h20, 3'd0, 6'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h00000000, 6'h01, 3'd1, 6'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h40000000, 6'h00, 3'd2, 6'h00, 1'b0, 1'b0, 1'b0);
    check("tp_sticky_21", a_sticky, 6'h21);
    check("tp_op_3", a_op, 16'd3);
    check("tp_trap_0", a_trap, 16'd0);

    // Single NaN trap, then pop.
    cyc(1'b1, 32'h7FC00000, 6'h04, 3'd3, 6'h04, 1'b0, 1'b0, 1'b0);
    check("tp_rd_valid", a_rd_valid, 1'b1);
    check("tp_rd_z", a_rd_z, 32'h7FC00000);
    check("tp_rd_flags", a_rd_flags, 6'h04);
    idle(1, 1'b1);
    check("tp_irq_cleared", a_irq, 1'b0);

    // Five back-to-back traps with no pops; then one pop lets the stalled fifth in.
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 32'hA000_0000 + i, 6'h04, 3'(i), 6'h04, 1'b0, 1'b0, 1'b0);
    check("tp_stall_ready", a_in_ready, 1'b0);
    check("tp_drop_sticky", b_drop, 1'b1);
    cyc(1'b1, 32'hA000_0004, 6'h04, 3'd4, 6'h04, 1'b0, 1'b0, 1'b1);
    check("tp_ready_after_pop", a_in_ready, 1'b1);
    cyc(1'b1, 32'hA000_0004, 6'h04, 3'd4, 6'h04, 1'b0, 1'b0, 1'b0);
    idle(10, 1'b1);

    // Clear coinciding with an accepted result, then counter saturation in the 4-bit instance.
    cyc(1'b1, 32'h1, 6'h02, 3'd0, 6'h00, 1'b1, 1'b0, 1'b0);
    check("tp_clr_sticky", a_sticky, 6'h02);
    check("tp_clr_drop", b_drop, 1'b0);
    cyc(1'b1, 32'h2, 6'h08, 3'd0, 6'h08, 1'b0, 1'b1, 1'b0);
    check("tp_clr_cnt_op", a_op, 16'd1);
    for (int i = 0; i < 20; i++) cyc(1'b1, 32'(i), 6'h00, 3'd0, 6'h00, 1'b0, 1'b0, 1'b1);
    check("tp_op_saturate", b_op, 4'd15);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 9) < 7, $urandom, 6'($urandom), 3'($urandom),
          6'($urandom) & 6'($urandom), $urandom_range(0, 19) == 0,
          $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0);
    end

    // Asynchronous reset with two queued records.
    idle(8, 1'b1);
    cyc(1'b1, 32'hDEAD0001, 6'h10, 3'd5, 6'h3F, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hDEAD0002, 6'h08, 3'd6, 6'h3F, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_rd_valid", a_rd_valid, 1'b0);
    check("arst_irq", b_irq, 1'b0);
    check("arst_op", a_op, 16'd0);
    check("arst_trap", b_trap, 4'd0);
    reset_model();
    @(negedge clk);
    rst = 1'b0;
    idle(2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
